// File: rtl/sift_match_pkg.sv
// Shared layout of a matched-descriptor memory entry, plus the reader state encoding.
// The writer stage imports the same definitions, so the entry format is defined only here.
package sift_match_pkg;

  localparam int unsigned ENTRY_W  = 47;
  localparam int unsigned POS_W    = 19;
  localparam int unsigned DIST_W   = 14;
  localparam int unsigned POS_LSB  = 28;
  localparam int unsigned MIN_LSB  = 14;
  localparam int unsigned MIN2_LSB = 0;

  localparam logic [DIST_W-1:0]  DIST_INIT  = 14'h3FFF;
  localparam logic [ENTRY_W-1:0] ENTRY_INIT = {{POS_W{1'b0}}, DIST_INIT, DIST_INIT};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_LAT,
    ST_CHK,
    ST_OUT,
    ST_CLR,
    ST_FIN
  } rd_state_e;

endpackage

// File: rtl/ratio_test.sv
// Lowe ratio test: accept when min/min2 < RATIO_NUM/RATIO_DEN, evaluated by cross-multiplication.
// An entry whose min was never written (still DIST_INIT) is never a match.
module ratio_test
  import sift_match_pkg::*;
#(
  parameter int unsigned RATIO_NUM = 4,
  parameter int unsigned RATIO_DEN = 5
) (
  input  logic [DIST_W-1:0] min,
  input  logic [DIST_W-1:0] min2,
  output logic              pass
);

  localparam int unsigned PROD_W = DIST_W + 4;

  logic [PROD_W-1:0] lhs;
  logic [PROD_W-1:0] rhs;

  always_comb begin
    lhs  = PROD_W'(min) * PROD_W'(RATIO_DEN);
    rhs  = PROD_W'(min2) * PROD_W'(RATIO_NUM);
    pass = (min != DIST_INIT) && (lhs < rhs);
  end

endmodule

// File: rtl/match_reader.sv
// Scans the matched-descriptor memory after a frame, streams ratio-test survivors
// on a valid/ready port, and rewrites every scanned entry to ENTRY_INIT.
module match_reader
  import sift_match_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned RATIO_NUM = 4,
  parameter int unsigned RATIO_DEN = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_W:0]    num_entry,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [ENTRY_W-1:0] mem_dout,
  output logic               mem_we,
  output logic [ENTRY_W-1:0] mem_din,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ADDR_W-1:0]  out_tar_idx,
  output logic [POS_W-1:0]   out_img_pos,
  output logic [DIST_W-1:0]  out_min,
  output logic [ADDR_W:0]    match_cnt
);

  rd_state_e          state_q, state_d;
  // idx/num carry one extra bit so a full 2^ADDR_W scan is representable
  logic [ADDR_W:0]    num_q, num_d;
  logic [ADDR_W:0]    idx_q, idx_d;
  logic [ADDR_W:0]    cnt_q, cnt_d;
  logic [ENTRY_W-1:0] entry_q, entry_d;
  logic [ADDR_W-1:0]  tar_q, tar_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic [DIST_W-1:0]  min_q, min_d;
  logic               pass;

  ratio_test #(
    .RATIO_NUM(RATIO_NUM),
    .RATIO_DEN(RATIO_DEN)
  ) u_ratio_test (
    .min (entry_q[MIN_LSB +: DIST_W]),
    .min2(entry_q[MIN2_LSB +: DIST_W]),
    .pass(pass)
  );

  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    entry_d = entry_q;
    tar_d   = tar_q;
    pos_d   = pos_q;
    min_d   = min_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          num_d   = num_entry;
          idx_d   = '0;
          cnt_d   = '0;
          state_d = (num_entry == '0) ? ST_FIN : ST_RD;
        end
      end
      ST_RD:  state_d = ST_LAT;
      ST_LAT: begin
        entry_d = mem_dout;
        state_d = ST_CHK;
      end
      ST_CHK: begin
        if (pass) begin
          tar_d   = idx_q[ADDR_W-1:0];
          pos_d   = entry_q[POS_LSB +: POS_W];
          min_d   = entry_q[MIN_LSB +: DIST_W];
          state_d = ST_OUT;
        end else begin
          state_d = ST_CLR;
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          cnt_d   = cnt_q + 1'b1;
          state_d = ST_CLR;
        end
      end
      ST_CLR: begin
        if (idx_q == num_q - 1'b1) begin
          state_d = ST_FIN;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = ST_RD;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      num_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      entry_q <= '0;
      tar_q   <= '0;
      pos_q   <= '0;
      min_q   <= '0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      entry_q <= entry_d;
      tar_q   <= tar_d;
      pos_q   <= pos_d;
      min_q   <= min_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_FIN);
  assign mem_we      = (state_q == ST_CLR);
  assign mem_addr    = idx_q[ADDR_W-1:0];
  assign mem_din     = ENTRY_INIT;
  assign out_valid   = (state_q == ST_OUT);
  assign out_tar_idx = tar_q;
  assign out_img_pos = pos_q;
  assign out_min     = min_q;
  assign match_cnt   = cnt_q;

endmodule
